// File: rtl/lane_bus_driver.sv
// Byte-stream to lane-qualified 32-bit bus transmitter (byte beats or packed word beats).
// Optional X injection on the lowest selected lane when LANE_X_INJECT_EN is defined.
module lane_bus_driver #(
  parameter int unsigned STARTUP_CYCLES = 8,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        word_mode,
  input  logic        hold,
  input  logic        inject_x,
  output logic [3:0]  select,
  output logic [31:0] bus,
  output logic [15:0] byte_count
);

  localparam int unsigned CNT_W = $clog2(STARTUP_CYCLES + 1) + 1;

  typedef enum logic {ST_STARTUP, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic              mode_q, mode_d;
  logic [31:0]       collect_q, collect_d;
  logic [31:0]       bus_q, bus_d;
  logic [3:0]        select_q, select_d;
  logic              in_ready_q, in_ready_d;
  logic [15:0]       count_q, count_d;

  logic              accept;
  logic              eff_mode;
  logic [4:0]        base;
  logic [31:0]       word_w;

  assign accept   = in_valid & in_ready_q & ~hold;
  // The mode latch only follows word_mode at a lane-0 accept.
  assign eff_mode = (lane_q == 2'd0) ? word_mode : mode_q;
  assign base     = {lane_q, 3'b000};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    mode_d     = mode_q;
    collect_d  = collect_q;
    bus_d      = bus_q;
    select_d   = select_q;
    count_d    = count_q;
    word_w     = collect_q;
    word_w[base +: 8] = in_data;
    for (int i = 0; i < 4; i++) begin
      if (in_last && (2'(i) > lane_q)) word_w[8*i +: 8] = PAD_BYTE;
    end

    // RUN is entered one edge early so in_ready is already high for the first accept edge.
    if (state_q == ST_STARTUP) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (32'(cnt_q) + 32'd2 >= STARTUP_CYCLES) state_d = ST_RUN;
    end
    in_ready_d = (state_d == ST_RUN) & ~hold;

    if (!hold) begin
      select_d = 4'b0000;
      bus_d    = 32'h0;
      if (accept) begin
        count_d = count_q + 16'd1;
        lane_d  = in_last ? 2'd0 : lane_q + 2'd1;
        if (lane_q == 2'd0) mode_d = word_mode;
        if (eff_mode) begin
          if ((lane_q == 2'd3) || in_last) begin
            select_d  = 4'b1111;
            bus_d     = word_w;
            collect_d = 32'h0;
          end else begin
            collect_d = word_w;
          end
        end else begin
          select_d = 4'b0001 << lane_q;
          bus_d    = 32'(in_data) << base;
        end
`ifdef LANE_X_INJECT_EN
        if (inject_x && (select_d != 4'b0000)) begin
          if (select_d == 4'b1111) bus_d[7:0] = 8'bx;
          else                     bus_d[base +: 8] = 8'bx;
        end
`endif
      end
    end
  end

`ifndef LANE_X_INJECT_EN
  logic unused_inject;
  assign unused_inject = inject_x;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_STARTUP;
      cnt_q      <= '0;
      lane_q     <= 2'd0;
      mode_q     <= 1'b0;
      collect_q  <= 32'h0;
      bus_q      <= 32'h0;
      select_q   <= 4'b0000;
      in_ready_q <= 1'b0;
      count_q    <= 16'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      mode_q     <= mode_d;
      collect_q  <= collect_d;
      bus_q      <= bus_d;
      select_q   <= select_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign select     = select_q;
  assign bus        = bus_q;
  assign byte_count = count_q;

endmodule
